// File: rtl/seg_pkg.sv
// seg_pkg: constants and the hex-to-segment table shared by the scan mux,
// its decoder and its bus interface.
//   SEG_OFF  : all segments dark (active-low, so every bit high)
//   HEX_SEG  : active-low segment pattern per hex digit, bit 0 = a .. bit 6 = g
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Index 15 is written first so that HEX_SEG[n] selects the pattern for n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: load bus and display drive of the seven-segment scanner.
//   load        : one-cycle strobe capturing value/blank_mask/blink_mask
//   value       : hex nibbles, digit i = value[4i+3:4i]
//   blank_mask  : bit i set = digit i dark
//   blink_mask  : bit i set = digit i blinks
//   seg         : active-low segments, seg[0]=a .. seg[6]=g
//   an          : active-low anodes, at most one low
//   frame_start : one-cycle pulse after each frame boundary
// master = the block issuing loads and watching the display, slave = scanner.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_pkg::*;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  seg_t                    seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output load, value, blank_mask, blink_mask,
    input  seg, an, frame_start
  );

  modport slave (
    input  load, value, blank_mask, blink_mask,
    output seg, an, frame_start
  );

endinterface

// File: rtl/hex_to_seg.sv
// hex_to_seg: purely combinational hex digit to active-low segment decoder.
//   hex : 4-bit digit
//   seg : active-low segments, bit 0 = a .. bit 6 = g
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver with frame-synchronous
// update, per-digit blanking and blinking.
//   clk  : system clock, rising edge
//   btnR : asynchronous active-high reset
//   bus  : seg_scan_mux_if slave (load/value/masks in, seg/an/frame_start out)
// Loads land in a pending buffer and are promoted to the display shadow only
// at a frame boundary, so a frame never shows a mix of old and new data.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 256
) (
  input  logic         clk,
  input  logic         btnR,
  seg_scan_mux_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  // scan position
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    boundary;

  // blink timing
  logic [FRM_W-1:0]        frm_reg, frm_next;
  logic                    blink_phase_reg, blink_phase_next;

  // pending load buffer
  logic                    pend_valid_reg, pend_valid_next;
  logic [4*NUM_DIGITS-1:0] pend_value_reg, pend_value_next;
  logic [NUM_DIGITS-1:0]   pend_blank_reg, pend_blank_next;
  logic [NUM_DIGITS-1:0]   pend_blink_reg, pend_blink_next;

  // display shadow, stable for a whole frame
  logic [4*NUM_DIGITS-1:0] shd_value_reg, shd_value_next;
  logic [NUM_DIGITS-1:0]   shd_blank_reg, shd_blank_next;
  logic [NUM_DIGITS-1:0]   shd_blink_reg, shd_blink_next;

  // output registers
  seg_t                    seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic                    frame_start_reg;

  logic                    digit_dark;
  logic                    lit;
  logic [3:0]              nibble;
  seg_t                    dec_seg;

  assign boundary = (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  always_comb begin
    frm_next         = frm_reg;
    blink_phase_next = blink_phase_reg;
    if (boundary) begin
      if (frm_reg == FRM_LAST) begin
        frm_next         = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        frm_next = frm_reg + FRM_W'(1);
      end
    end
  end

  // A load on the boundary cycle goes straight to the shadow so it shows in
  // the very next frame; whatever was pending is superseded by it.
  always_comb begin
    pend_valid_next = pend_valid_reg;
    pend_value_next = pend_value_reg;
    pend_blank_next = pend_blank_reg;
    pend_blink_next = pend_blink_reg;
    shd_value_next  = shd_value_reg;
    shd_blank_next  = shd_blank_reg;
    shd_blink_next  = shd_blink_reg;
    if (bus.load && boundary) begin
      shd_value_next  = bus.value;
      shd_blank_next  = bus.blank_mask;
      shd_blink_next  = bus.blink_mask;
      pend_valid_next = 1'b0;
    end else if (bus.load) begin
      pend_value_next = bus.value;
      pend_blank_next = bus.blank_mask;
      pend_blink_next = bus.blink_mask;
      pend_valid_next = 1'b1;
    end else if (boundary && pend_valid_reg) begin
      shd_value_next  = pend_value_reg;
      shd_blank_next  = pend_blank_reg;
      shd_blink_next  = pend_blink_reg;
      pend_valid_next = 1'b0;
    end
  end

  // Blank wins over blink simply because either one darkens the digit.
  assign digit_dark = shd_blank_reg[idx_reg] |
                      (shd_blink_reg[idx_reg] & blink_phase_reg);
  // Slot position 0 is kept dark to hide anode switching ghosting.
  assign lit    = (cnt_reg != '0) && !digit_dark;
  assign nibble = shd_value_reg[{idx_reg, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (dec_seg)
  );

  assign seg_next = lit ? dec_seg : SEG_OFF;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_next[gi] = !(lit && (idx_reg == IDX_W'(gi)));
  end

  always_ff @(posedge clk or posedge btnR) begin
    if (btnR) begin
      cnt_reg         <= '0;
      idx_reg         <= '0;
      frm_reg         <= '0;
      blink_phase_reg <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_value_reg  <= '0;
      pend_blank_reg  <= '1;
      pend_blink_reg  <= '0;
      shd_value_reg   <= '0;
      shd_blank_reg   <= '1;
      shd_blink_reg   <= '0;
      seg_reg         <= SEG_OFF;
      an_reg          <= '1;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      frm_reg         <= frm_next;
      blink_phase_reg <= blink_phase_next;
      pend_valid_reg  <= pend_valid_next;
      pend_value_reg  <= pend_value_next;
      pend_blank_reg  <= pend_blank_next;
      pend_blink_reg  <= pend_blink_next;
      shd_value_reg   <= shd_value_next;
      shd_blank_reg   <= shd_blank_next;
      shd_blink_reg   <= shd_blink_next;
      seg_reg         <= seg_next;
      an_reg          <= an_next;
      frame_start_reg <= boundary;
    end
  end

  assign bus.seg         = seg_reg;
  assign bus.an          = an_reg;
  assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (4 digits, 4 cycles/slot, blink every 2
// frames). The reference model works from absolute time since reset: frame
// number, slot and digit follow by division, and the shadow for a frame is the
// last load issued during any earlier frame.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BD = 2;
  localparam int F  = ND * RD;

  typedef struct {
    int         s;
    logic [15:0] v;
    logic [3:0]  bl;
    logic [3:0]  bk;
  } load_t;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  logic  clk  = 1'b0;
  logic  btnR = 1'b0;
  int    checks   = 0;
  int    failures = 0;
  int    kcnt     = 0;
  load_t hist[$];
  exp_t  exp_q[$];

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk  (clk),
    .btnR (btnR),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Segment pattern from the list of lit segment letters of each glyph.
  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    string      lit;
    logic [6:0] r;
    case (h)
      4'h0: lit = "abcdef";
      4'h1: lit = "bc";
      4'h2: lit = "abdeg";
      4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";
      4'h5: lit = "acdfg";
      4'h6: lit = "acdefg";
      4'h7: lit = "abc";
      4'h8: lit = "abcdefg";
      4'h9: lit = "abcdfg";
      4'hA: lit = "abcefg";
      4'hB: lit = "cdefg";
      4'hC: lit = "adef";
      4'hD: lit = "bcdeg";
      4'hE: lit = "adefg";
      default: lit = "aefg";
    endcase
    r = 7'h7F;
    for (int i = 0; i < lit.len(); i++) r[int'(lit[i]) - 97] = 1'b0;
    return r;
  endfunction

  // Outputs after edge k (k >= 1) describe the scan state at time s = k-1.
  function automatic exp_t model(input int k);
    exp_t        e;
    int          s, f, c, d;
    logic [15:0] v;
    logic [3:0]  bl, bk;
    logic        phase;
    s  = k - 1;
    f  = s / F;
    c  = s % RD;
    d  = (s / RD) % ND;
    v  = 16'h0;
    bl = 4'hF;
    bk = 4'h0;
    foreach (hist[i]) begin
      if (hist[i].s < f * F) begin
        v  = hist[i].v;
        bl = hist[i].bl;
        bk = hist[i].bk;
      end
    end
    phase = ((f / BD) % 2) == 1;
    e.k   = k;
    e.fs  = (s % F) == F - 1;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    if (c != 0 && !bl[d] && !(bk[d] && phase)) begin
      e.an[d] = 1'b0;
      e.seg   = ref_seg(v[4*d +: 4]);
    end
    return e;
  endfunction

  // Monitor: one scoreboard entry per clock, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg || bus.frame_start !== e.fs) begin
        failures++;
        $display("FAIL scan k=%0d an=%b want %b seg=%b want %b fs=%b want %b",
                 e.k, bus.an, e.an, bus.seg, e.seg, bus.frame_start, e.fs);
      end
    end
  end

  task automatic step(input logic ld, input logic [15:0] v,
                      input logic [3:0] bl, input logic [3:0] bk);
    load_t h;
    bus.load       = ld;
    bus.value      = v;
    bus.blank_mask = bl;
    bus.blink_mask = bk;
    @(posedge clk);
    if (ld) begin
      h.s = kcnt; h.v = v; h.bl = bl; h.bk = bk;
      hist.push_back(h);
      $display("load s=%0d value=%h blank=%b blink=%b", kcnt, v, bl, bk);
    end
    kcnt++;
    exp_q.push_back(model(kcnt));
    #1;
    bus.load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL %s an=%b want 1111 seg=%b want 1111111 fs=%b want 0",
               name, bus.an, bus.seg, bus.frame_start);
    end
  endtask

  // Reset asserted mid-low-phase; dark outputs must appear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 btnR = 1'b1;
    #1 check_dark("async_reset");
    exp_q.delete();
    hist.delete();
    kcnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1 check_dark("held_reset");
    @(negedge clk);
    btnR = 1'b0;
    $display("reset released");
  endtask

  task automatic to_boundary();
    while (kcnt % F != F - 1) idle(1);
  endtask

  initial begin
    bus.load       = 1'b0;
    bus.value      = '0;
    bus.blank_mask = '0;
    bus.blink_mask = '0;

    do_reset();
    idle(2 * F);                                   // dark with no load

    step(1'b1, 16'h1234, 4'h0, 4'h0);              // plain digits
    idle(3 * F);

    idle(3);
    step(1'b1, 16'h1111, 4'h0, 4'h0);              // last load of a frame wins
    idle(2);
    step(1'b1, 16'h2222, 4'h0, 4'h0);
    idle(2 * F);

    step(1'b1, 16'h89AB, 4'h0, 4'h1);              // digit 0 blinks
    idle(6 * F);

    step(1'b1, 16'hCDEF, 4'h4, 4'h6);              // blank beats blink
    idle(5 * F);

    to_boundary();
    step(1'b1, 16'h5670, 4'h0, 4'h0);              // load on boundary cycle
    idle(2 * F);

    idle(5);
    step(1'b1, 16'h4321, 4'h0, 4'h0);              // pending lost on reset
    idle(3);
    do_reset();
    idle(2 * F);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 11) == 0) begin
        step(1'b1, 16'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      end else begin
        idle(1);
      end
    end
    to_boundary();
    step(1'b1, 16'hFED0, 4'h0, 4'h0);
    idle(2 * F);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal minimum 2.
REQ-003 SHALL have parameter BLINK_DIV, default 256, frames per blink half-period; legal minimum 1.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port btnR  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port load  in  1  one-cycle strobe capturing value/blank_mask/blink_mask.
REQ-007 SHALL have port value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i].
REQ-008 SHALL have port blank_mask  in  NUM_DIGITS  bit i set = digit i dark.
REQ-009 SHALL have port blink_mask  in  NUM_DIGITS  bit i set = digit i blinks.
REQ-010 SHALL have port seg  out  7  active-low segments, seg[0]=a .. seg[6]=g, registered.
REQ-011 SHALL have port an  out  NUM_DIGITS  active-low anodes, registered, at most one low.
REQ-012 SHALL have port frame_start  out  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-013 SHALL count slot counter 0..REFRESH_DIV-1, wrapping; on wrap advance digit index idx, NUM_DIGITS-1 wraps to 0.
REQ-014 SHALL define frame boundary as the cycle with counter==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
REQ-015 SHALL on load capture inputs into pending registers and set pending_valid; a later load before a boundary overwrites (last wins).
REQ-016 SHALL at a frame boundary copy pending into display shadow and clear pending_valid; with no pending, shadow unchanged.
REQ-017 SHALL, when load coincides with a boundary, put that cycle's load data directly into shadow (pending bypassed, pending_valid cleared).
REQ-018 SHALL never display a mix of old and new shadow within one frame.
REQ-019 SHALL register outputs: an/seg reflect idx/counter/shadow one cycle after those update; frame_start high in the cycle after the boundary.
REQ-020 SHALL drive an all-high and seg=7'h7F when the registered counter value is 0 (one-cycle anti-ghost blanking per slot).
REQ-021 SHALL otherwise drive an[idx] low only, seg = hex decode of shadow nibble idx.
REQ-022 SHALL decode 0-F standard hex; e.g. 4 -> 7'b0011001, 0 -> 7'b1000000, F -> 7'b0001110.
REQ-023 SHALL treat a digit with shadow blank bit set as dark: an all-high, seg=7'h7F, for its slot.
REQ-024 SHALL count frames and toggle blink_phase every BLINK_DIV frames; digits with shadow blink bit set are dark while blink_phase=1.
REQ-025 SHALL give blank priority over blink.

Reset
REQ-026 SHALL on btnR asynchronously set: counter 0, idx 0, blink_phase 0, frame counter 0, pending_valid 0, shadow value 0, shadow blank all-1, shadow blink 0, an all-1, seg 7'h7F, frame_start 0.
REQ-027 SHALL stay dark after reset until first load reaches shadow at a boundary.
REQ-028 SHALL discard a pending load when reset asserts mid-frame.

Structure
REQ-029 SHALL place SEG_OFF (7'h7F) constant and hex-to-segment table in shared package seg_pkg.
REQ-030 SHALL use one combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out).

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2)
REQ-031 SHALL cover: btnR pulse -> an=4'b1111, seg=7'h7F immediately, stays dark with no load.
REQ-032 SHALL cover: load value=16'h1234, masks 0 -> from next frame, an 1110/1101/1011/0111 each low 3 of 4 cycles, digit0 seg=7'b0011001.
REQ-033 SHALL cover: loads 16'h1111 then 16'h2222 in one frame -> only 2 shown, never 1.
REQ-034 SHALL cover: blink_mask=4'b0001 -> digit0 lit 2 frames, dark 2 frames, others steady.
REQ-035 SHALL cover: load on boundary cycle -> new data visible in the immediately following frame; frame_start pulse one cycle later.
REQ-036 SHALL cover: btnR mid-frame with pending load -> dark, idx 0, pending lost.
